pipeline_ctrl_seq: RTL and testbench
====================================

// Module: pipeline_ctrl_seq
// PURPOSE
//  Central sequencer for the 5-stage pipeline's stall, flush and freeze controls.
//  Consumes raw hazard indications and emits per-stage write enables and flushes:
//  load-use (decode), taken branch/jump (EX), data-memory wait (MEM).
//  Handles multi-cycle stalls/flushes and their priorities; keeps stall/flush statistics.
// PARAMETERS
//  LU_STALL    1   bubble cycles per load-use hazard (1..3; 2 when no MEM->EX forward)
//  FLUSH_EXTRA 0   extra fetch-kill cycles after a taken branch (0..3, imem latency)
//  CNT_W       16  width of statistic counters
// PORTS
//  clk          in   1      system clock, rising edge
//  rst          in   1      asynchronous, active-high reset
//  ld_use_hz    in   1      load in EX writes Rd read by instr in ID (Rd!=x0 checked upstream)
//  br_taken     in   1      branch/jump in EX resolved taken; PC mux selects target
//  mem_busy     in   1      data memory not ready; whole pipe must hold
//  clr_cnt      in   1      synchronous clear of both statistic counters
//  pc_we        out  1      PC register write enable
//  if_id_we     out  1      IF/ID register write enable
//  if_id_flush  out  1      IF/ID register clear (inserts NOP)
//  id_ex_flush  out  1      ID/EX control clear (inserts bubble)
//  ex_mem_we    out  1      EX/MEM register write enable
//  mem_wb_we    out  1      MEM/WB register write enable
//  state_o      out  2      current state: 0 RUN, 1 STALL, 2 FLUSH, 3 MWAIT
//  stall_cnt    out  CNT_W  cycles with pc_we=0 (rst excluded), saturating
//  flush_cnt    out  CNT_W  accepted taken-branch events, saturating
// BEHAVIOUR
//  - Outputs are combinational from state + inputs (same-cycle response); state regs async-reset.
//  - rst=1: state=RUN, cnt_rem=0, ret_state=RUN, both counters 0; outputs forced:
//    all *_we=0, if_id_flush=1, id_ex_flush=1. After release, RUN with no inputs: all we=1, flushes 0.
//  - Priority each cycle: mem_busy > br_taken > ld_use_hz > state default.
//  - mem_busy=1 (any state): all *_we=0, flushes 0. From non-MWAIT: ret_state<=state, state<=MWAIT.
//    cnt_rem frozen. mem_busy=0 in MWAIT: state<=ret_state; same cycle emits that state's outputs
//    (re-evaluating br_taken/ld_use_hz with normal priority).
//  - br_taken (not busy): pc_we=1, if_id_we=1, if_id_flush=1, id_ex_flush=1, ex/mem_wb_we=1.
//    flush_cnt+1. FLUSH_EXTRA=0 -> RUN, else FLUSH with cnt_rem=FLUSH_EXTRA. Aborts STALL/FLUSH.
//  - ld_use_hz in RUN: pc_we=0, if_id_we=0, id_ex_flush=1, if_id_flush=0, ex/mem_wb_we=1.
//    LU_STALL=1 -> stay RUN; else STALL with cnt_rem=LU_STALL-1.
//  - STALL: same outputs as load-use cycle; cnt_rem-1; leave to RUN when cnt_rem==1 at edge.
//    ld_use_hz in STALL ignored (the instruction in ID is the same one).
//  - FLUSH: pc_we=1, if_id_we=1, if_id_flush=1, id_ex_flush=0, ex/mem_wb_we=1;
//    cnt_rem-1, RUN when cnt_rem==1 at edge.
//  - Counters: clr_cnt beats increment; increment saturates at 2^CNT_W-1 (no wrap).
//    stall_cnt counts MWAIT and STALL/load-use cycles alike.
//  - Illegal state encoding unreachable; default branch -> RUN.
// TESTING
//  1 Reset released, inputs 0 -> state_o=0, pc_we=if_id_we=ex_mem_we=mem_wb_we=1, flushes 0.
//  2 LU_STALL=2, ld_use_hz pulse 1 cycle -> pc_we=0 for 2 cycles, id_ex_flush=1 both, stall_cnt=2.
//  3 FLUSH_EXTRA=1, br_taken pulse -> if_id_flush=1 for 2 cycles, id_ex_flush=1 1st only, flush_cnt=1.
//  4 LU_STALL=2: ld_use_hz, then mem_busy 3 cycles in STALL -> MWAIT 3 cycles, resume STALL,
//    cnt_rem intact; total pc_we=0 for 5 cycles, stall_cnt=5.
//  5 br_taken and ld_use_hz same cycle -> branch wins: pc_we=1, both flushes 1, stall_cnt unchanged.
//  6 CNT_W=4: hold mem_busy 20 cycles -> stall_cnt saturates at 15; clr_cnt=1 -> 0 next edge;
//    rst asserted mid-STALL -> state_o=0 async, outputs forced to reset values.

Source files
------------

// File: rtl/pipeline_ctrl_seq.sv
// Pipeline stall/flush/freeze sequencer: turns raw hazard flags into per-stage
// write enables and flushes, and keeps saturating stall/flush statistics.
//
// state | meaning
// RUN   | normal issue; load-use bubble handled in place when LU_STALL=1
// STALL | extra load-use bubble cycles, cnt_rem_q counts them down
// FLUSH | extra fetch-kill cycles after a taken branch, cnt_rem_q counts them down
// MWAIT | whole pipe frozen on data memory; ret_state_q remembers where to resume
module pipeline_ctrl_seq #(
    parameter int LU_STALL    = 1,
    parameter int FLUSH_EXTRA = 0,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ld_use_hz,
    input  logic             br_taken,
    input  logic             mem_busy,
    input  logic             clr_cnt,
    output logic             pc_we,
    output logic             if_id_we,
    output logic             if_id_flush,
    output logic             id_ex_flush,
    output logic             ex_mem_we,
    output logic             mem_wb_we,
    output logic [1:0]       state_o,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        STALL = 2'd1,
        FLUSH = 2'd2,
        MWAIT = 2'd3
    } state_t;

    state_t     state_q, state_d;
    state_t     ret_state_q, ret_state_d;
    state_t     eff_state;
    logic [1:0] cnt_rem_q, cnt_rem_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;
    logic       br_accept;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= RUN;
            ret_state_q <= RUN;
            cnt_rem_q   <= 2'd0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            ret_state_q <= ret_state_d;
            cnt_rem_q   <= cnt_rem_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    // Leaving MWAIT behaves exactly like the remembered state in the same cycle.
    assign eff_state = (state_q == MWAIT) ? ret_state_q : state_q;

    always_comb begin
        state_d     = state_q;
        ret_state_d = ret_state_q;
        cnt_rem_d   = cnt_rem_q;
        br_accept   = 1'b0;
        pc_we       = 1'b1;
        if_id_we    = 1'b1;
        if_id_flush = 1'b0;
        id_ex_flush = 1'b0;
        ex_mem_we   = 1'b1;
        mem_wb_we   = 1'b1;

        if (mem_busy) begin
            pc_we     = 1'b0;
            if_id_we  = 1'b0;
            ex_mem_we = 1'b0;
            mem_wb_we = 1'b0;
            if (state_q != MWAIT) begin
                ret_state_d = state_q;
                state_d     = MWAIT;
            end
        end else if (br_taken) begin
            br_accept   = 1'b1;
            if_id_flush = 1'b1;
            id_ex_flush = 1'b1;
            if (FLUSH_EXTRA == 0) begin
                state_d = RUN;
            end else begin
                state_d   = FLUSH;
                cnt_rem_d = 2'(FLUSH_EXTRA);
            end
        end else begin
            case (eff_state)
                RUN: begin
                    state_d = RUN;
                    if (ld_use_hz) begin
                        pc_we       = 1'b0;
                        if_id_we    = 1'b0;
                        id_ex_flush = 1'b1;
                        if (LU_STALL > 1) begin
                            state_d   = STALL;
                            cnt_rem_d = 2'(LU_STALL - 1);
                        end
                    end
                end
                STALL: begin
                    pc_we       = 1'b0;
                    if_id_we    = 1'b0;
                    id_ex_flush = 1'b1;
                    cnt_rem_d   = cnt_rem_q - 2'd1;
                    state_d     = (cnt_rem_q == 2'd1) ? RUN : STALL;
                end
                FLUSH: begin
                    if_id_flush = 1'b1;
                    cnt_rem_d   = cnt_rem_q - 2'd1;
                    state_d     = (cnt_rem_q == 2'd1) ? RUN : FLUSH;
                end
                default: begin
                    state_d = RUN;
                end
            endcase
        end

        if (rst) begin
            pc_we       = 1'b0;
            if_id_we    = 1'b0;
            if_id_flush = 1'b1;
            id_ex_flush = 1'b1;
            ex_mem_we   = 1'b0;
            mem_wb_we   = 1'b0;
        end
    end

    // Clear wins over increment; increments stick at all-ones.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (clr_cnt) begin
            stall_cnt_d = '0;
            flush_cnt_d = '0;
        end else begin
            if (!pc_we && !(&stall_cnt_q)) stall_cnt_d = stall_cnt_q + 1'b1;
            if (br_accept && !(&flush_cnt_q)) flush_cnt_d = flush_cnt_q + 1'b1;
        end
    end

    assign state_o   = state_q;
    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;

endmodule

// File: tb/tb_pipeline_ctrl_seq.sv
// Directed bench for pipeline_ctrl_seq: a per-cycle vector table on a LU_STALL=2,
// FLUSH_EXTRA=1 instance plus hand sequences for saturation, clear and async reset.
module tb_pipeline_ctrl_seq;

    logic clk = 1'b0;
    logic rst, ld_use_hz, br_taken, mem_busy, clr_cnt;

    logic        a_pc_we, a_if_id_we, a_if_id_flush, a_id_ex_flush, a_ex_mem_we, a_mem_wb_we;
    logic [1:0]  a_state;
    logic [15:0] a_stall_cnt, a_flush_cnt;
    logic        b_pc_we, b_if_id_we, b_if_id_flush, b_id_ex_flush, b_ex_mem_we, b_mem_wb_we;
    logic [1:0]  b_state;
    logic [3:0]  b_stall_cnt, b_flush_cnt;
    logic [5:0]  a_outs;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    pipeline_ctrl_seq #(.LU_STALL(2), .FLUSH_EXTRA(1), .CNT_W(16)) dut_a (
        .clk(clk), .rst(rst), .ld_use_hz(ld_use_hz), .br_taken(br_taken),
        .mem_busy(mem_busy), .clr_cnt(clr_cnt),
        .pc_we(a_pc_we), .if_id_we(a_if_id_we), .if_id_flush(a_if_id_flush),
        .id_ex_flush(a_id_ex_flush), .ex_mem_we(a_ex_mem_we), .mem_wb_we(a_mem_wb_we),
        .state_o(a_state), .stall_cnt(a_stall_cnt), .flush_cnt(a_flush_cnt)
    );

    pipeline_ctrl_seq #(.LU_STALL(1), .FLUSH_EXTRA(0), .CNT_W(4)) dut_b (
        .clk(clk), .rst(rst), .ld_use_hz(ld_use_hz), .br_taken(br_taken),
        .mem_busy(mem_busy), .clr_cnt(clr_cnt),
        .pc_we(b_pc_we), .if_id_we(b_if_id_we), .if_id_flush(b_if_id_flush),
        .id_ex_flush(b_id_ex_flush), .ex_mem_we(b_ex_mem_we), .mem_wb_we(b_mem_wb_we),
        .state_o(b_state), .stall_cnt(b_stall_cnt), .flush_cnt(b_flush_cnt)
    );

    // {pc_we, if_id_we, if_id_flush, id_ex_flush, ex_mem_we, mem_wb_we}
    assign a_outs = {a_pc_we, a_if_id_we, a_if_id_flush, a_id_ex_flush, a_ex_mem_we, a_mem_wb_we};

    typedef struct {
        logic        ld;
        logic        br;
        logic        busy;
        logic        clr;
        logic [5:0]  outs;
        logic [1:0]  st;
        logic [15:0] sc;
        logic [15:0] fc;
    } vec_t;

    localparam int NV = 25;
    vec_t vecs [NV];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    initial begin
        //              ld    br    busy  clr   outs       st    sc  fc
        vecs[0]  = '{1'b0, 1'b0, 1'b0, 1'b0, 6'b110011, 2'd0, 16'd0, 16'd0};
        vecs[1]  = '{1'b1, 1'b0, 1'b0, 1'b0, 6'b000111, 2'd0, 16'd0, 16'd0};
        vecs[2]  = '{1'b0, 1'b0, 1'b0, 1'b0, 6'b000111, 2'd1, 16'd1, 16'd0};
        vecs[3]  = '{1'b0, 1'b0, 1'b0, 1'b0, 6'b110011, 2'd0, 16'd2, 16'd0};
        vecs[4]  = '{1'b0, 1'b1, 1'b0, 1'b0, 6'b111111, 2'd0, 16'd2, 16'd0};
        vecs[5]  = '{1'b0, 1'b0, 1'b0, 1'b0, 6'b111011, 2'd2, 16'd2, 16'd1};
        vecs[6]  = '{1'b0, 1'b0, 1'b0, 1'b0, 6'b110011, 2'd0, 16'd2, 16'd1};
        vecs[7]  = '{1'b1, 1'b0, 1'b0, 1'b0, 6'b000111, 2'd0, 16'd2, 16'd1};
        vecs[8]  = '{1'b0, 1'b0, 1'b1, 1'b0, 6'b000000, 2'd1, 16'd3, 16'd1};
        vecs[9]  = '{1'b0, 1'b0, 1'b1, 1'b0, 6'b000000, 2'd3, 16'd4, 16'd1};
        vecs[10] = '{1'b0, 1'b0, 1'b1, 1'b0, 6'b000000, 2'd3, 16'd5, 16'd1};
        vecs[11] = '{1'b0, 1'b0, 1'b0, 1'b0, 6'b000111, 2'd3, 16'd6, 16'd1};
        vecs[12] = '{1'b0, 1'b0, 1'b0, 1'b0, 6'b110011, 2'd0, 16'd7, 16'd1};
        vecs[13] = '{1'b1, 1'b1, 1'b0, 1'b0, 6'b111111, 2'd0, 16'd7, 16'd1};
        vecs[14] = '{1'b0, 1'b0, 1'b0, 1'b0, 6'b111011, 2'd2, 16'd7, 16'd2};
        vecs[15] = '{1'b1, 1'b0, 1'b0, 1'b0, 6'b000111, 2'd0, 16'd7, 16'd2};
        vecs[16] = '{1'b0, 1'b1, 1'b0, 1'b0, 6'b111111, 2'd1, 16'd8, 16'd2};
        vecs[17] = '{1'b0, 1'b0, 1'b1, 1'b0, 6'b000000, 2'd2, 16'd8, 16'd3};
        vecs[18] = '{1'b0, 1'b1, 1'b0, 1'b0, 6'b111111, 2'd3, 16'd9, 16'd3};
        vecs[19] = '{1'b1, 1'b0, 1'b0, 1'b0, 6'b111011, 2'd2, 16'd9, 16'd4};
        vecs[20] = '{1'b0, 1'b0, 1'b0, 1'b1, 6'b110011, 2'd0, 16'd9, 16'd4};
        vecs[21] = '{1'b0, 1'b0, 1'b0, 1'b0, 6'b110011, 2'd0, 16'd0, 16'd0};
        vecs[22] = '{1'b0, 1'b0, 1'b1, 1'b1, 6'b000000, 2'd0, 16'd0, 16'd0};
        vecs[23] = '{1'b0, 1'b0, 1'b0, 1'b0, 6'b110011, 2'd3, 16'd0, 16'd0};
        vecs[24] = '{1'b0, 1'b0, 1'b0, 1'b0, 6'b110011, 2'd0, 16'd0, 16'd0};

        rst = 1'b1; ld_use_hz = 1'b0; br_taken = 1'b0; mem_busy = 1'b0; clr_cnt = 1'b0;
        #11;
        chk("reset_outs", 32'(a_outs), 32'b001100);
        chk("reset_state", 32'(a_state), 32'd0);
        chk("reset_stall_cnt", 32'(a_stall_cnt), 32'd0);
        chk("reset_b_ex_mem_we", 32'(b_ex_mem_we), 32'd0);
        #1 rst = 1'b0;
        @(posedge clk); #1;

        for (int i = 0; i < NV; i++) begin
            ld_use_hz = vecs[i].ld;
            br_taken  = vecs[i].br;
            mem_busy  = vecs[i].busy;
            clr_cnt   = vecs[i].clr;
            @(negedge clk);
            chk($sformatf("vec%0d_outs", i), 32'(a_outs), 32'(vecs[i].outs));
            chk($sformatf("vec%0d_state", i), 32'(a_state), 32'(vecs[i].st));
            chk($sformatf("vec%0d_stall_cnt", i), 32'(a_stall_cnt), 32'(vecs[i].sc));
            chk($sformatf("vec%0d_flush_cnt", i), 32'(a_flush_cnt), 32'(vecs[i].fc));
            @(posedge clk); #1;
        end
        ld_use_hz = 1'b0; br_taken = 1'b0; mem_busy = 1'b0; clr_cnt = 1'b0;

        // Saturation on the 4-bit instance, then synchronous clear.
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        mem_busy = 1'b1;
        repeat (20) @(posedge clk);
        #1;
        chk("sat_b_stall_cnt", 32'(b_stall_cnt), 32'd15);
        chk("sat_a_stall_cnt", 32'(a_stall_cnt), 32'd20);
        chk("sat_a_state", 32'(a_state), 32'd3);
        mem_busy = 1'b0;
        clr_cnt  = 1'b1;
        @(posedge clk); #1;
        clr_cnt = 1'b0;
        chk("clr_b_stall_cnt", 32'(b_stall_cnt), 32'd0);
        chk("clr_a_stall_cnt", 32'(a_stall_cnt), 32'd0);
        chk("clr_a_state", 32'(a_state), 32'd0);

        // LU_STALL=1 instance absorbs a load-use in RUN; the other enters STALL.
        ld_use_hz = 1'b1;
        @(negedge clk);
        chk("b_lu_pc_we", 32'(b_pc_we), 32'd0);
        chk("b_lu_id_ex_flush", 32'(b_id_ex_flush), 32'd1);
        @(posedge clk); #1;
        ld_use_hz = 1'b0;
        chk("b_lu_state", 32'(b_state), 32'd0);
        chk("b_lu_stall_cnt", 32'(b_stall_cnt), 32'd1);
        chk("a_lu_state", 32'(a_state), 32'd1);

        // Asynchronous reset in the middle of STALL.
        #2 rst = 1'b1;
        #1;
        chk("async_rst_state", 32'(a_state), 32'd0);
        chk("async_rst_outs", 32'(a_outs), 32'b001100);
        chk("async_rst_stall_cnt", 32'(a_stall_cnt), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        #1;
        chk("post_rst_outs", 32'(a_outs), 32'b110011);

        // FLUSH_EXTRA=0 instance returns straight to RUN after a branch.
        br_taken = 1'b1;
        @(posedge clk); #1;
        br_taken = 1'b0;
        chk("b_br_state", 32'(b_state), 32'd0);
        chk("b_br_flush_cnt", 32'(b_flush_cnt), 32'd1);
        chk("a_br_state", 32'(a_state), 32'd2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
